seq_dibit_serializer: RTL and testbench

Upstream feeder for the 2-bit-symbol sequence detectors in the seq_detect block family. Accepts parallel words over a valid/ready handshake and emits them as one 2-bit symbol {A,B} per clock. The detector samples {A,B} every cycle, so the block sustains a gap-free symbol stream across back-to-back words. Symbols are buffered in a one-word holding register plus a shift register.

---
 rtl/seq_dibit_serializer.sv | 110 +++++++++++
 tb/tb_seq_dibit_serializer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_dibit_serializer.sv
// seq_dibit_serializer
//   Feeds the 2-bit-symbol sequence detectors. It accepts parallel words over
//   a valid/ready handshake and emits one dibit {A,B} per clock. A one-word
//   holding register sits behind the shift register, so back-to-back words
//   stream out with no idle symbols between them.
//
// Ports
//   clk        rising-edge clock
//   clr        asynchronous reset, active low
//   flush      synchronous clear of the shifter and the holding register
//   in_data    parallel input word (DATA_W bits)
//   in_valid   in_data is valid
//   in_ready   a word can be accepted this cycle (driven only by registers)
//   A, B       current symbol; A is the more significant bit
//   sym_valid  {A,B} carries a real symbol
//   sym_last   the current symbol is the last dibit of its word
//   busy       sym_valid | holding register occupied
module seq_dibit_serializer #(
  parameter int unsigned DATA_W    = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter logic [1:0]  IDLE_SYM  = 2'b00
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              flush,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              A,
  output logic              B,
  output logic              sym_valid,
  output logic              sym_last,
  output logic              busy
);

  localparam int unsigned N     = DATA_W / 2;
  localparam int unsigned CW    = $clog2(N + 1);
  localparam logic [CW-1:0] N_CNT = CW'(N);
  localparam logic [CW-1:0] ONE   = CW'(1);

  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] hold;
  logic              hold_v;
  logic [CW-1:0]     cnt;
  logic [1:0]        head;
  logic              accept;

  // The outgoing dibit always sits at the head end of the shifter; the
  // shift direction follows the dibit order.
  always_comb begin
    head    = '0;
    shifted = '0;
    if (MSB_FIRST) begin
      head    = shreg[DATA_W-1 -: 2];
      shifted = {shreg[DATA_W-3:0], 2'b00};
    end else begin
      head    = shreg[1:0];
      shifted = {2'b00, shreg[DATA_W-1:2]};
    end
  end

  assign in_ready  = ~hold_v;
  assign accept    = in_valid & ~hold_v;
  assign sym_valid = (cnt != '0);
  assign sym_last  = (cnt == ONE);
  assign busy      = sym_valid | hold_v;
  assign {A, B}    = sym_valid ? head : IDLE_SYM;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      shreg  <= '0;
      hold   <= '0;
      hold_v <= 1'b0;
      cnt    <= '0;
    end else if (flush) begin
      // A word accepted on this edge is deliberately discarded.
      shreg  <= '0;
      hold_v <= 1'b0;
      cnt    <= '0;
    end else if (cnt == '0) begin
      if (accept) begin
        shreg <= in_data;
        cnt   <= N_CNT;
      end
    end else if (cnt != ONE) begin
      shreg <= shifted;
      cnt   <= cnt - ONE;
      if (accept) begin
        hold   <= in_data;
        hold_v <= 1'b1;
      end
    end else begin
      // Last dibit on display: refill from hold first (in_ready is low
      // whenever hold is occupied), else straight from the input.
      if (hold_v) begin
        shreg  <= hold;
        hold_v <= 1'b0;
        cnt    <= N_CNT;
      end else if (accept) begin
        shreg <= in_data;
        cnt   <= N_CNT;
      end else begin
        shreg <= '0;
        cnt   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_seq_dibit_serializer.sv
// Testbench for seq_dibit_serializer: two instances (MSB-first and
// LSB-first) share the same stimulus; each has its own expected-symbol
// queue that a negedge monitor pops whenever sym_valid is high.
module tb_seq_dibit_serializer;

  logic       clk = 1'b0;
  logic       clr, flush, in_valid;
  logic [7:0] in_data;
  logic       in_ready, a, b, sv, sl, busy;
  logic       in_ready_l, a_l, b_l, sv_l, sl_l, busy_l;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [2:0] qm[$];
  logic [2:0] ql[$];
  logic [2:0] em, el;
  bit started_m = 1'b0;
  bit started_l = 1'b0;

  seq_dibit_serializer #(.DATA_W(8), .MSB_FIRST(1'b1), .IDLE_SYM(2'b00)) dut (
    .clk(clk), .clr(clr), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .A(a), .B(b), .sym_valid(sv), .sym_last(sl), .busy(busy)
  );

  seq_dibit_serializer #(.DATA_W(8), .MSB_FIRST(1'b0), .IDLE_SYM(2'b00)) dut_l (
    .clk(clk), .clr(clr), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_l), .A(a_l), .B(b_l), .sym_valid(sv_l), .sym_last(sl_l), .busy(busy_l)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitors: entries are {A,B,sym_last}.
  always @(negedge clk) begin
    if (sv) begin
      if (qm.size() == 0) chk("msb_unexpected_symbol", 1, 0);
      else begin
        em = qm.pop_front();
        chk("msb_symbol", int'({a, b, sl}), int'(em));
      end
      started_m = 1'b1;
    end else if (started_m && qm.size() > 0) begin
      chk("msb_stream_gap", int'(sv), 1);
    end else begin
      started_m = 1'b0;
      chk("msb_idle_sym", int'({a, b, sl}), 0);
    end
  end

  always @(negedge clk) begin
    if (sv_l) begin
      if (ql.size() == 0) chk("lsb_unexpected_symbol", 1, 0);
      else begin
        el = ql.pop_front();
        chk("lsb_symbol", int'({a_l, b_l, sl_l}), int'(el));
      end
      started_l = 1'b1;
    end else if (started_l && ql.size() > 0) begin
      chk("lsb_stream_gap", int'(sv_l), 1);
    end else begin
      started_l = 1'b0;
      chk("lsb_idle_sym", int'({a_l, b_l, sl_l}), 0);
    end
  end

  // Hand-computed dibits of one word for both orderings.
  task automatic push_word(input logic [1:0] m0, m1, m2, m3,
                           input logic [1:0] l0, l1, l2, l3);
    qm.push_back({m0, 1'b0}); qm.push_back({m1, 1'b0});
    qm.push_back({m2, 1'b0}); qm.push_back({m3, 1'b1});
    ql.push_back({l0, 1'b0}); ql.push_back({l1, 1'b0});
    ql.push_back({l2, 1'b0}); ql.push_back({l3, 1'b1});
  endtask

  // Present a word and return the cycle of the accepting edge; returns #1
  // after that edge.
  task automatic send_word(input logic [7:0] d, output int acc);
    bit ok = 1'b0;
    int guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!ok && guard < 40) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    acc = cyc;
  endtask

  task automatic drain();
    int guard = 0;
    while ((qm.size() != 0 || ql.size() != 0 || busy || busy_l) && guard < 60) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("drain_timeout", int'(guard < 60), 1);
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_sym_valid"}, int'(sv), 0);
    chk({name, "_sym_last"}, int'(sl), 0);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_ab"}, int'({a, b}), 0);
    chk({name, "_in_ready"}, int'(in_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int t0, t1, t2;
    clr = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;

    // 1. Reset and idle
    repeat (3) begin
      @(posedge clk); #1;
      chk_idle("reset");
    end
    clr = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      chk_idle("idle");
    end

    // 2. Single word 1B: 00,01,10,11 (LSB-first 11,10,01,00)
    send_word(8'h1B, t0);
    push_word(2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00);
    in_valid = 1'b0;
    chk("latency_sym_valid", int'(sv), 1);
    chk("latency_first_ab", int'({a, b}), 0);
    drain();
    chk_idle("after_single");

    // 3. Back-to-back 1B, E4
    send_word(8'h1B, t0);
    push_word(2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00);
    send_word(8'hE4, t1);
    push_word(2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 2'b01, 2'b10, 2'b11);
    in_valid = 1'b0;
    chk("b2b_accept_spacing", t1 - t0, 1);
    chk("b2b_ready_low_held", int'(in_ready), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("b2b_ready_low_last", int'(in_ready), 0);
    @(posedge clk); #1;
    chk("b2b_ready_back", int'(in_ready), 1);
    drain();

    // 4. Backpressure: 1B, E4, 55
    send_word(8'h1B, t0);
    push_word(2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00);
    send_word(8'hE4, t1);
    push_word(2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 2'b01, 2'b10, 2'b11);
    send_word(8'h55, t2);
    push_word(2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01);
    in_valid = 1'b0;
    chk("bp_second_spacing", t1 - t0, 1);
    chk("bp_third_spacing", t2 - t1, 4);
    drain();

    // 5a. Flush after the second symbol of 1B with E4 held
    send_word(8'h1B, t0);
    push_word(2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00);
    in_data = 8'hE4;
    @(posedge clk); #1;
    chk("flush_pre_hold", int'(busy & ~in_ready), 1);
    flush = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    qm.delete(); ql.delete();
    chk_idle("flush");
    repeat (2) @(posedge clk);
    #1;
    chk_idle("post_flush");

    // 5b. Asynchronous clr mid-word
    send_word(8'h1B, t0);
    push_word(2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00);
    in_data = 8'hE4;
    @(posedge clk); #2;
    chk("clr_pre_busy", int'(busy), 1);
    qm.delete(); ql.delete();
    clr = 1'b0;
    in_valid = 1'b0;
    #1;
    chk_idle("async_clr");
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk); #1;
    chk_idle("post_clr");

    // 6. 7C: MSB 01,11,11,00 ; LSB 00,11,11,01
    send_word(8'h7C, t0);
    push_word(2'b01, 2'b11, 2'b11, 2'b00, 2'b00, 2'b11, 2'b11, 2'b01);
    in_valid = 1'b0;
    drain();
    chk_idle("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
